// File: rtl/shifter_pkg.sv
// Shared types and constants for the iterative right shifter.
// Holds the FSM state encoding and the fixed operand/stage widths.
package shifter_pkg;

  localparam int N  = 32;
  localparam int S  = 5;
  localparam int KW = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/shift_right_stage.sv
// One conditional right-shift stage: shifts by 2^k when en, else passes.
// Ports: data/fill/k/en in, res out (combinational).
module shift_right_stage
  import shifter_pkg::*;
#(
  parameter int W  = N,
  parameter int NS = S,
  parameter int KB = KW
) (
  input  logic [W-1:0]  data,
  input  logic          fill,
  input  logic [KB-1:0] k,
  input  logic          en,
  output logic [W-1:0]  res
);

  logic [W-1:0] cand [NS];

  for (genvar j = 0; j < NS; j++) begin : g_cand
    assign cand[j] = {{(2**j){fill}}, data[W-1:2**j]};
  end

  always_comb begin
    res = data;
    for (int j = 0; j < NS; j++) begin
      if (en && (int'(k) == j)) res = cand[j];
    end
  end

endmodule

// File: rtl/shift_right_iterative.sv
// Iterative right shifter: one power-of-two stage per cycle, 5 cycles.
// Ports: clk, rst, in_valid/in_ready/in/shamt/arith, out_valid/out_ready/out.
module shift_right_iterative
  import shifter_pkg::*;
#(
  parameter int N = shifter_pkg::N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic                 arith,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out
);

  localparam int SS = $clog2(N);
  localparam int KB = $clog2(SS);

  state_t          state;
  logic [KB-1:0]   k;
  logic [N-1:0]    work;
  logic [SS-1:0]   shamt_q;
  logic            arith_q;
  logic [N-1:0]    stage_res;
  logic            stage_en;
  logic            fill;

  // work msb still holds captured sign whenever arith is set
  assign fill     = arith_q & work[N-1];
  assign stage_en = (state == BUSY) && (int'(k) < SS) && shamt_q[k];
  assign out      = work;

  shift_right_stage #(
    .W  (N),
    .NS (SS),
    .KB (KB)
  ) u_stage (
    .data (work),
    .fill (fill),
    .k    (k),
    .en   (stage_en),
    .res  (stage_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      work      <= '0;
      shamt_q   <= '0;
      arith_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in;
            shamt_q  <= shamt;
            arith_q  <= arith;
            k        <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
          end
        end
        BUSY: begin
          work <= stage_res;
          k    <= k + 1'b1;
          if (int'(k) == SS-1) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_iterative.sv
// Self-checking bench for shift_right_iterative.
// Directed corner cases, reset abort and random vectors with stalls.
module tb_shift_right_iterative;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  shift_right_iterative #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_d),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                            input int s,
                                            input logic ar);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < s; i++)
      r = {(ar ? a[31] : 1'b0), r[31:1]};
    return r;
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [4:0] s,
                        input logic ar,
                        input int stall,
                        input string tag);
    logic [31:0] exp;
    int lat;
    exp = ref_shift(a, int'(s), ar);
    chk({tag, "_ready_pre"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_d     = a;
    shamt    = s;
    arith    = ar;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
      in_d     = $urandom;
      shamt    = 5'($urandom);
      arith    = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_result"}, out, exp);
    chk({tag, "_done_ready"}, {31'b0, in_ready}, 32'd0);
    repeat (stall) begin
      in_valid = 1'b1;
      in_d     = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_hold_out"}, out, exp);
      chk({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = '0;
    shamt     = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_out", out, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(32'h8000_0000, 5'd4, 1'b0, 0, "msb_s4_log");
    run_op(32'h8000_0000, 5'd4, 1'b1, 0, "msb_s4_ari");
    run_op(32'h8000_0000, 5'd31, 1'b1, 0, "msb_s31_ari");
    run_op(32'h8000_0000, 5'd31, 1'b0, 0, "msb_s31_log");
    run_op(32'h1234_5678, 5'd0, 1'b1, 0, "s0");
    run_op(32'hDEAD_BEEF, 5'd13, 1'b1, 3, "backpressure");
    chk("fixed_s4_log", ref_shift(32'h8000_0000, 4, 1'b0),
        32'h0800_0000);

    // abort in the 3rd BUSY cycle
    in_valid = 1'b1;
    in_d     = 32'hFFFF_0000;
    shamt    = 5'd3;
    arith    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_out", out, 32'h0);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd1);
    lat = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("abort_no_result", 32'(lat), 32'd0);
    rst = 1'b0;
    run_op(32'h0F0F_0F0F, 5'd7, 1'b0, 0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
